// File: rtl/ioseq_pkg.sv
// rtl/ioseq_pkg.sv - shared types and defaults for the I/O register cycle sequencer
package ioseq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    localparam int STROBE_CYC_DEF  = 2;
    localparam int TIMEOUT_CYC_DEF = 15;
    localparam int STRB_W          = 3;
    localparam int TMO_W           = 4;

endpackage

// File: rtl/ioseq_timer.sv
// rtl/ioseq_timer.sv - strobe down-counter plus wait-extension counter
module ioseq_timer
    import ioseq_pkg::*;
#(
    parameter int STROBE_CYC  = STROBE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    input  logic iowait,
    output logic last,
    output logic ext_full
);

    logic [STRB_W-1:0] cnt;
    logic [TMO_W-1:0]  ext;

    assign last     = (cnt <= STRB_W'(1));
    assign ext_full = (ext == TMO_W'(TIMEOUT_CYC));

    // Extensions only accumulate once the nominal strobe has run down.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            ext <= '0;
        end else if (load) begin
            cnt <= STRB_W'(STROBE_CYC);
            ext <= '0;
        end else if (run) begin
            if (!last)
                cnt <= cnt - STRB_W'(1);
            else if (iowait && !ext_full)
                ext <= ext + TMO_W'(1);
        end
    end

endmodule

// File: rtl/ioseq.sv
// rtl/ioseq.sv - I/O register cycle sequencer: setup, strobe with wait/timeout, hold, done
module ioseq
    import ioseq_pkg::*;
#(
    parameter int STROBE_CYC  = STROBE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [1:0]  be,
    input  logic [15:0] wdata,
    input  logic        iowait,
    input  logic [15:0] din,
    output logic [15:0] a,
    output logic        intdev,
    output logic        reads,
    output logic        oet,
    output logic        wet,
    output logic        intswe,
    output logic [15:0] dout,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata
);

    state_t     state, nxt;
    logic       rw_r;
    logic [1:0] be_r;
    logic       timeout;
    logic       to_set;
    logic       last, ext_full;
    logic       rw_sel;
    logic       in_cycle;

    ioseq_timer #(
        .STROBE_CYC  (STROBE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == SETUP),
        .run      (state == STROBE),
        .iowait   (iowait),
        .last     (last),
        .ext_full (ext_full)
    );

    always_comb begin
        nxt    = state;
        to_set = 1'b0;
        case (state)
            IDLE:   if (req) nxt = SETUP;
            SETUP:  nxt = STROBE;
            STROBE: begin
                if (last) begin
                    if (!iowait) begin
                        nxt = HOLD;
                    end else if (ext_full) begin
                        nxt    = HOLD;
                        to_set = 1'b1;
                    end
                end
            end
            HOLD:   nxt = DONE;
            DONE:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so strobes are glitch-free.
    assign rw_sel   = (state == IDLE) ? rw : rw_r;
    assign in_cycle = (nxt == SETUP) || (nxt == STROBE) || (nxt == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rw_r    <= 1'b0;
            be_r    <= 2'b00;
            timeout <= 1'b0;
            a       <= '0;
            dout    <= '0;
            rdata   <= '0;
            intdev  <= 1'b0;
            reads   <= 1'b0;
            oet     <= 1'b0;
            wet     <= 1'b0;
            intswe  <= 1'b0;
            busy    <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && req) begin
                a    <= addr;
                dout <= wdata;
                rw_r <= rw;
                be_r <= be;
            end
            if (state == SETUP)
                timeout <= 1'b0;
            else if (to_set)
                timeout <= 1'b1;
            if (state == STROBE && nxt == HOLD && rw_r)
                rdata <= to_set ? 16'hFFFF : din;
            intdev <= in_cycle;
            reads  <= in_cycle && rw_sel;
            oet    <= (nxt == STROBE) && rw_r;
            wet    <= (nxt == STROBE) && !rw_r;
            intswe <= (nxt == STROBE) && !rw_r && (be_r == 2'b11);
            busy   <= (nxt != IDLE);
            ack    <= (nxt == DONE);
            err    <= (nxt == DONE) && timeout;
        end
    end

endmodule

// File: doc/ioseq.md
IOSEQ -- requirements
Module: ioseq

Interface
REQ-001 Parameters: STROBE_CYC, default 2, strobe width in clocks (legal 1..7); TIMEOUT_CYC, default 15, maximum wait-extension clocks (legal 1..15).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  1  requester asks for an I/O register cycle; sampled only in IDLE.
REQ-005 rw  input  1  1 = read, 0 = write; sampled with req.
REQ-006 addr  input  16  register byte address; sampled with req.
REQ-007 be  input  2  byte enables, bit0 = low byte; sampled with req.
REQ-008 wdata  input  16  write data; sampled with req.
REQ-009 iowait  input  1  target extends the strobe while high.
REQ-010 din  input  16  internal read-data bus from the register file.
REQ-011 a  output  16  address to the I/O decoder.
REQ-012 intdev  output  1  internal-device cycle in progress.
REQ-013 reads  output  1  cycle is a read; low outside cycles.
REQ-014 oet  output  1  read output-enable strobe.
REQ-015 wet  output  1  write-enable strobe, any byte enable.
REQ-016 intswe  output  1  write strobe, word writes only (be = 2'b11).
REQ-017 dout  output  16  write data driven to the internal bus.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 ack  output  1  one-clock completion pulse.
REQ-020 err  output  1  one-clock pulse coincident with ack when the cycle timed out.
REQ-021 rdata  output  16  captured read data; holds until the next read completes.

Function
REQ-022 FSM states SHALL be IDLE, SETUP, STROBE, HOLD, DONE.
REQ-023 IDLE with req=1 SHALL register addr/rw/be/wdata and go to SETUP next clock; req=0 stays IDLE.
REQ-024 SETUP SHALL last exactly 1 clock with a, intdev=1, reads=rw and dout valid, and all strobes low.
REQ-025 STROBE SHALL assert oet (read) or wet (write; intswe also when be=2'b11) for STROBE_CYC clocks, then go to HOLD.
REQ-026 If iowait=1 on the last strobe clock, STROBE SHALL extend one clock per clock iowait stays high, up to TIMEOUT_CYC extension clocks.
REQ-027 When extensions reach TIMEOUT_CYC with iowait still high, the FSM SHALL go to HOLD and set a timeout flag.
REQ-028 rdata SHALL capture din on the final STROBE clock of a read, unless the cycle timed out, in which case rdata SHALL load 16'hFFFF.
REQ-029 HOLD SHALL last 1 clock with strobes low, and a, intdev, reads and dout unchanged.
REQ-030 DONE SHALL pulse ack (and err if timed out), drop intdev and reads, and return to IDLE.
REQ-031 Minimum cycle with no wait SHALL be 3+STROBE_CYC clocks from req sample to ack (5 with defaults).
REQ-032 The earliest next req SHALL be sampled in the clock after DONE; back-to-back cycles SHALL never overlap strobes.
REQ-033 req, addr, rw, be and wdata changing while busy=1 SHALL have no effect.
REQ-034 A write with be=2'b00 SHALL still run the full cycle, with wet asserted and intswe low.
REQ-035 oet and wet SHALL never be high in the same clock, and SHALL be registered outputs free of glitches.

Reset
REQ-036 reset SHALL force IDLE and clear both counters and the timeout flag.
REQ-037 On reset, a, dout and rdata SHALL be 0, and intdev, reads, oet, wet, intswe, busy, ack and err SHALL be 0.
REQ-038 Reset asserted mid-cycle SHALL drop all strobes on the next clock and SHALL produce no ack.

Structure
REQ-039 A shared package SHALL hold the state enum, the STROBE_CYC and TIMEOUT_CYC defaults, and the counter width (3 bits strobe, 4 bits timeout).
REQ-040 One sub-module, ioseq_timer, SHALL implement the loadable down-counter with an extension/timeout count; the FSM stays in ioseq.

Verification
REQ-041 Read: addr=16'h0004, rw=1, din=16'h1234, iowait=0 -> oet high 2 clocks, ack 5 clocks after req, rdata=16'h1234, err=0.
REQ-042 Word write: addr=16'h0030, be=2'b11, wdata=16'hA5A5 -> wet and intswe high 2 clocks, dout=16'hA5A5 from SETUP to DONE.
REQ-043 Byte write: be=2'b01 -> wet high 2 clocks, intswe low throughout.
REQ-044 Wait: iowait high for 3 clocks at strobe end -> oet high 5 clocks, ack at clock 8, err=0; iowait stuck high -> 15 extension clocks, ack+err, rdata=16'hFFFF.
REQ-045 Reset asserted during STROBE -> next clock all outputs 0, busy=0, no ack; a following req completes normally.
REQ-046 req held high continuously -> consecutive acks 6 clocks apart, with at least 1 strobe-free SETUP clock between strobes.
